// File: rtl/lsu_pkg.sv
// Shared encodings and defaults for the load/store unit: request opcodes,
// controller states and the legal data window.
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_RSVD  = 2'b11
  } lsu_op_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    WR         = 3'd3,
    RESP       = 3'd4
  } lsu_state_e;

  localparam logic [7:0] LSU_DATA_BASE  = 8'd64;
  localparam logic [7:0] LSU_DATA_LIMIT = 8'd127;

endpackage

// File: rtl/addr_range_check.sv
// Combinational legality check: an address is legal when it lies inside
// the inclusive unsigned window [BASE, LIMIT].
module addr_range_check
  import lsu_pkg::*;
#(
  parameter logic [7:0] BASE  = LSU_DATA_BASE,
  parameter logic [7:0] LIMIT = LSU_DATA_LIMIT
) (
  input  logic [7:0] addr,
  output logic       legal
);

  assign legal = (addr >= BASE) && (addr <= LIMIT);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store/copy unit in front of a byte-wide data memory
// with a one-cycle registered read port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [7:0] DATA_BASE  = LSU_DATA_BASE,
  parameter logic [7:0] DATA_LIMIT = LSU_DATA_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_src,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_fault,
  output logic [7:0] fault_count,
  output logic [7:0] data_address,
  output logic [7:0] write_data,
  output logic       write_enable,
  input  logic [7:0] read_data
);

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is an unconditional
  // one-cycle pulse (the core cannot stall it).

  lsu_state_e state, next_state;
  lsu_op_e    req_op_e, op_q;
  logic [7:0] src_addr, dst_q, byte_q;
  logic       accept, src_ok, dst_ok, req_fault, fault_q;

  assign req_op_e  = lsu_op_e'(req_op);
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  // LOAD reads from req_addr, COPY reads from req_src.
  assign src_addr  = (req_op_e == OP_COPY) ? req_src : req_addr;

  addr_range_check #(.BASE(DATA_BASE), .LIMIT(DATA_LIMIT)) u_src_check (
    .addr  (src_addr),
    .legal (src_ok)
  );

  addr_range_check #(.BASE(DATA_BASE), .LIMIT(DATA_LIMIT)) u_dst_check (
    .addr  (req_addr),
    .legal (dst_ok)
  );

  always_comb begin
    req_fault = 1'b0;
    case (req_op_e)
      OP_LOAD:  req_fault = !src_ok;
      OP_STORE: req_fault = !dst_ok;
      OP_COPY:  req_fault = !src_ok || !dst_ok;
      default:  req_fault = 1'b1;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault)                  next_state = RESP;
          else if (req_op_e == OP_STORE)  next_state = WR;
          else                            next_state = RD_ISSUE;
        end
      end
      RD_ISSUE:   next_state = RD_CAPTURE;
      RD_CAPTURE: next_state = (op_q == OP_COPY) ? WR : RESP;
      WR:         next_state = RESP;
      RESP:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_LOAD;
      dst_q   <= '0;
      fault_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op_e;
        dst_q   <= req_addr;
        fault_q <= req_fault;
      end
      if (state == RD_CAPTURE) byte_q <= read_data;
    end
  end

  // Memory-side outputs are loaded on entry to the state that owns them, so
  // they are valid for the whole RD_ISSUE / WR cycle and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_address <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
    end else begin
      write_enable <= (next_state == WR);
      if (next_state == RD_ISSUE) data_address <= src_addr;
      if (next_state == WR) begin
        data_address <= (state == IDLE) ? req_addr  : dst_q;
        write_data   <= (state == IDLE) ? req_wdata : read_data;
      end
    end
  end

  // The response is registered out of RESP, giving LOAD/STORE/COPY/fault
  // completions 3/2/4/1 edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_fault  <= 1'b0;
      resp_data   <= '0;
      fault_count <= '0;
    end else begin
      resp_valid <= (state == RESP);
      resp_fault <= (state == RESP) && fault_q;
      resp_data  <= ((state == RESP) && !fault_q && (op_q != OP_STORE)) ? byte_q : 8'h00;
      if ((state == RESP) && fault_q && (fault_count != 8'hFF))
        fault_count <= fault_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: registered-read data memory model,
// reference model of the architectural effect of each request, per-feature tests.
module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_addr = 8'h00, req_src = 8'h00, req_wdata = 8'h00;
  logic       resp_valid, resp_fault, write_enable;
  logic [7:0] resp_data, fault_count, data_address, write_data;
  logic [7:0] read_data = 8'h00;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int oob_wr = 0;
  int ref_fault_count = 0;
  logic        preload = 1'b0;
  logic [7:0]  ref_mem [0:255];
  logic [7:0]  mem [0:63];
  logic [15:0] exp_q[$];
  logic [15:0] act_wr_q[$];

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_src      (req_src),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_fault   (resp_fault),
    .fault_count  (fault_count),
    .data_address (data_address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_data    (read_data)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- data memory: 64 lines at 64..127, registered read ----------------
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i + 64];
    end else if (write_enable) begin
      if (data_address >= 8'd64 && data_address <= 8'd127) mem[6'(data_address - 8'd64)] <= write_data;
      else oob_wr <= oob_wr + 1;
    end else begin
      if (data_address >= 8'd64 && data_address <= 8'd127) read_data <= mem[6'(data_address - 8'd64)];
      else read_data <= 8'h00;
    end
  end

  always @(negedge clk) if (write_enable) act_wr_q.push_back({data_address, write_data});

  // ---------------- reference model ----------------
  function automatic bit legal(input logic [7:0] a);
    return (a >= 8'd64) && (a <= 8'd127);
  endfunction

  task automatic model_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] src,
                           input logic [7:0] wd, output logic e_fault, output logic [7:0] e_data,
                           output int e_lat);
    e_fault = 1'b0; e_data = 8'h00; e_lat = 1;
    case (op)
      2'b00: begin e_fault = !legal(addr); e_data = ref_mem[addr]; e_lat = 3; end
      2'b01: begin
        e_fault = !legal(addr); e_lat = 2;
        if (!e_fault) begin ref_mem[addr] = wd; exp_q.push_back({addr, wd}); end
      end
      2'b10: begin
        e_fault = !legal(src) || !legal(addr); e_data = ref_mem[src]; e_lat = 4;
        if (!e_fault) begin ref_mem[addr] = ref_mem[src]; exp_q.push_back({addr, ref_mem[src]}); end
      end
      default: e_fault = 1'b1;
    endcase
    if (e_fault) begin
      e_data = 8'h00; e_lat = 1;
      if (ref_fault_count < 255) ref_fault_count++;
    end
  endtask

  // ---------------- driver ----------------
  // Presents one request, scrambles the request inputs while busy, and
  // reports latency (edges after acceptance), response fields and whether
  // resp_valid was still high one cycle later.
  task automatic run_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] src,
                         input logic [7:0] wd, output int lat, output logic [7:0] rdata,
                         output logic rfault, output logic after);
    int n;
    int unsigned acc;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_src = src; req_wdata = wd;
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr = 8'($urandom); req_src = 8'($urandom); req_wdata = 8'($urandom);
    lat = -1; rdata = 8'hxx; rfault = 1'bx;
    n = 0;
    while (n < 10) begin
      @(negedge clk); n++;
      if (resp_valid) begin lat = int'(cyc - acc); break; end
    end
    rdata = resp_data; rfault = resp_fault;
    @(negedge clk);
    after = resp_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 64; i < 128; i++) ref_mem[i] = 8'($urandom);
    rst_n = 1'b0; preload = 1'b1;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    n_checks += 8;
    if (req_ready !== 1'b1)    begin n_fail++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    if (resp_valid !== 1'b0)   begin n_fail++; $display("FAIL reset resp_valid: got %b expected 0", resp_valid); end
    if (resp_fault !== 1'b0)   begin n_fail++; $display("FAIL reset resp_fault: got %b expected 0", resp_fault); end
    if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset write_enable: got %b expected 0", write_enable); end
    if (resp_data !== 8'h00)   begin n_fail++; $display("FAIL reset resp_data: got %h expected 00", resp_data); end
    if (data_address !== 8'h00) begin n_fail++; $display("FAIL reset data_address: got %h expected 00", data_address); end
    if (write_data !== 8'h00)  begin n_fail++; $display("FAIL reset write_data: got %h expected 00", write_data); end
    if (fault_count !== 8'h00) begin n_fail++; $display("FAIL reset fault_count: got %h expected 00", fault_count); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_directed();
    logic [1:0] t_op [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
    logic [7:0] t_addr [4] = '{8'd66, 8'd66, 8'd100, 8'd100};
    logic [7:0] t_src [4] = '{8'd0, 8'd0, 8'd66, 8'd0};
    logic [7:0] t_wd [4] = '{8'h5A, 8'h00, 8'h00, 8'h00};
    logic [7:0] want [4] = '{8'h00, 8'h5A, 8'h5A, 8'h5A};
    int lat, e_lat; logic [7:0] rdata, e_data; logic rfault, e_fault, after;
    for (int i = 0; i < 4; i++) begin
      model_req(t_op[i], t_addr[i], t_src[i], t_wd[i], e_fault, e_data, e_lat);
      run_req(t_op[i], t_addr[i], t_src[i], t_wd[i], lat, rdata, rfault, after);
      n_checks += 7;
      if (lat !== e_lat)     begin n_fail++; $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, e_lat); end
      if (rdata !== want[i]) begin n_fail++; $display("FAIL directed[%0d] resp_data: got %h expected %h", i, rdata, want[i]); end
      if (rdata !== e_data)  begin n_fail++; $display("FAIL directed[%0d] resp_data vs model: got %h expected %h", i, rdata, e_data); end
      if (rfault !== e_fault) begin n_fail++; $display("FAIL directed[%0d] resp_fault: got %b expected %b", i, rfault, e_fault); end
      if (after !== 1'b0)    begin n_fail++; $display("FAIL directed[%0d] resp_valid width: got %b expected 0", i, after); end
      if (act_wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL directed[%0d] write count: got %0d expected %0d", i, act_wr_q.size(), exp_q.size()); end
      if (fault_count !== 8'(ref_fault_count)) begin n_fail++; $display("FAIL directed[%0d] fault_count: got %0d expected %0d", i, fault_count, ref_fault_count); end
      if (act_wr_q.size() > 0 && exp_q.size() > 0) begin
        n_checks++;
        if (act_wr_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL directed[%0d] write addr/data: got %h expected %h", i, act_wr_q[0], exp_q[0]); end
      end
      act_wr_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_faults();
    logic [1:0] t_op [3] = '{2'b00, 2'b01, 2'b11};
    logic [7:0] t_addr [3] = '{8'd63, 8'd128, 8'd80};
    int lat, e_lat; logic [7:0] rdata, e_data; logic rfault, e_fault, after;
    for (int i = 0; i < 3; i++) begin
      model_req(t_op[i], t_addr[i], 8'd70, 8'hC3, e_fault, e_data, e_lat);
      run_req(t_op[i], t_addr[i], 8'd70, 8'hC3, lat, rdata, rfault, after);
      n_checks += 5;
      if (lat !== 1)         begin n_fail++; $display("FAIL fault[%0d] latency: got %0d expected 1", i, lat); end
      if (rfault !== 1'b1)   begin n_fail++; $display("FAIL fault[%0d] resp_fault: got %b expected 1", i, rfault); end
      if (rdata !== 8'h00)   begin n_fail++; $display("FAIL fault[%0d] resp_data: got %h expected 00", i, rdata); end
      if (after !== 1'b0)    begin n_fail++; $display("FAIL fault[%0d] resp_valid width: got %b expected 0", i, after); end
      if (act_wr_q.size() != 0) begin n_fail++; $display("FAIL fault[%0d] write count: got %0d expected 0", i, act_wr_q.size()); end
      act_wr_q.delete(); exp_q.delete();
    end
    n_checks++;
    if (fault_count !== 8'd3) begin n_fail++; $display("FAIL fault_count after three faults: got %0d expected 3", fault_count); end
  endtask

  task automatic test_boundary();
    logic [1:0] t_op [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    logic [7:0] t_addr [8] = '{8'd64, 8'd127, 8'd127, 8'd127, 8'd70, 8'd100, 8'd128, 8'd255};
    logic [7:0] t_src [8] = '{8'd0, 8'd0, 8'd0, 8'd64, 8'd70, 8'd63, 8'd100, 8'd0};
    int lat, e_lat; logic [7:0] rdata, e_data; logic rfault, e_fault, after;
    for (int i = 0; i < 8; i++) begin
      model_req(t_op[i], t_addr[i], t_src[i], 8'hA5, e_fault, e_data, e_lat);
      run_req(t_op[i], t_addr[i], t_src[i], 8'hA5, lat, rdata, rfault, after);
      n_checks += 5;
      if (lat !== e_lat)      begin n_fail++; $display("FAIL boundary[%0d] latency: got %0d expected %0d", i, lat, e_lat); end
      if (rdata !== e_data)   begin n_fail++; $display("FAIL boundary[%0d] resp_data: got %h expected %h", i, rdata, e_data); end
      if (rfault !== e_fault) begin n_fail++; $display("FAIL boundary[%0d] resp_fault: got %b expected %b", i, rfault, e_fault); end
      if (act_wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL boundary[%0d] write count: got %0d expected %0d", i, act_wr_q.size(), exp_q.size()); end
      if (fault_count !== 8'(ref_fault_count)) begin n_fail++; $display("FAIL boundary[%0d] fault_count: got %0d expected %0d", i, fault_count, ref_fault_count); end
      if (act_wr_q.size() > 0 && exp_q.size() > 0) begin
        n_checks++;
        if (act_wr_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL boundary[%0d] write addr/data: got %h expected %h", i, act_wr_q[0], exp_q[0]); end
      end
      act_wr_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_random();
    int lat, e_lat; logic [7:0] rdata, e_data; logic rfault, e_fault, after;
    logic [1:0] op; logic [7:0] addr, src, wd;
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(60, 131));
      src  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(60, 131));
      wd   = 8'($urandom);
      model_req(op, addr, src, wd, e_fault, e_data, e_lat);
      run_req(op, addr, src, wd, lat, rdata, rfault, after);
      n_checks += 6;
      if (lat !== e_lat)      begin n_fail++; $display("FAIL random[%0d] latency op=%0d: got %0d expected %0d", i, op, lat, e_lat); end
      if (rdata !== e_data)   begin n_fail++; $display("FAIL random[%0d] resp_data op=%0d: got %h expected %h", i, op, rdata, e_data); end
      if (rfault !== e_fault) begin n_fail++; $display("FAIL random[%0d] resp_fault op=%0d: got %b expected %b", i, op, rfault, e_fault); end
      if (after !== 1'b0)     begin n_fail++; $display("FAIL random[%0d] resp_valid width: got %b expected 0", i, after); end
      if (act_wr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random[%0d] write count: got %0d expected %0d", i, act_wr_q.size(), exp_q.size()); end
      if (fault_count !== 8'(ref_fault_count)) begin n_fail++; $display("FAIL random[%0d] fault_count: got %0d expected %0d", i, fault_count, ref_fault_count); end
      if (act_wr_q.size() > 0 && exp_q.size() > 0) begin
        n_checks++;
        if (act_wr_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL random[%0d] write addr/data: got %h expected %h", i, act_wr_q[0], exp_q[0]); end
      end
      act_wr_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_fault_saturation();
    int lat, e_lat; logic [7:0] rdata, e_data; logic rfault, e_fault, after;
    logic [1:0] op; logic [7:0] addr;
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      op = 2'($urandom_range(0, 3));
      addr = (op == 2'b11) ? 8'd80 : 8'($urandom_range(128, 255));
      model_req(op, addr, 8'd70, 8'h11, e_fault, e_data, e_lat);
      run_req(op, addr, 8'd70, 8'h11, lat, rdata, rfault, after);
      if (rfault !== 1'b1 || lat !== 1) bad++;
      act_wr_q.delete(); exp_q.delete();
    end
    n_checks += 3;
    if (bad != 0) begin n_fail++; $display("FAIL saturation fault responses: got %0d bad expected 0", bad); end
    if (fault_count !== 8'd255) begin n_fail++; $display("FAIL saturation fault_count: got %0d expected 255", fault_count); end
    if (fault_count !== 8'(ref_fault_count)) begin n_fail++; $display("FAIL saturation fault_count vs model: got %0d expected %0d", fault_count, ref_fault_count); end
  endtask

  task automatic test_reset_mid_copy();
    int seen_resp = 0;
    int lat, e_lat; logic [7:0] rdata, e_data; logic rfault, e_fault, after;
    act_wr_q.delete();
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 8'd101; req_src = 8'd66;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 6;
    if (req_ready !== 1'b1)     begin n_fail++; $display("FAIL midreset req_ready: got %b expected 1", req_ready); end
    if (write_enable !== 1'b0)  begin n_fail++; $display("FAIL midreset write_enable: got %b expected 0", write_enable); end
    if (resp_valid !== 1'b0)    begin n_fail++; $display("FAIL midreset resp_valid: got %b expected 0", resp_valid); end
    if (data_address !== 8'h00) begin n_fail++; $display("FAIL midreset data_address: got %h expected 00", data_address); end
    if (write_data !== 8'h00)   begin n_fail++; $display("FAIL midreset write_data: got %h expected 00", write_data); end
    if (fault_count !== 8'h00)  begin n_fail++; $display("FAIL midreset fault_count: got %0d expected 0", fault_count); end
    ref_fault_count = 0;
    repeat (3) begin @(negedge clk); if (resp_valid) seen_resp++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (resp_valid) seen_resp++; end
    n_checks += 4;
    if (seen_resp != 0)          begin n_fail++; $display("FAIL midreset resp pulses: got %0d expected 0", seen_resp); end
    if (act_wr_q.size() != 0)    begin n_fail++; $display("FAIL midreset writes: got %0d expected 0", act_wr_q.size()); end
    if (req_ready !== 1'b1)      begin n_fail++; $display("FAIL midreset req_ready after release: got %b expected 1", req_ready); end
    if (mem[101 - 64] !== ref_mem[101]) begin n_fail++; $display("FAIL midreset dst content: got %h expected %h", mem[101 - 64], ref_mem[101]); end
    model_req(2'b00, 8'd101, 8'd0, 8'd0, e_fault, e_data, e_lat);
    run_req(2'b00, 8'd101, 8'd0, 8'd0, lat, rdata, rfault, after);
    n_checks += 2;
    if (rdata !== e_data) begin n_fail++; $display("FAIL midreset reload data: got %h expected %h", rdata, e_data); end
    if (lat !== e_lat)    begin n_fail++; $display("FAIL midreset reload latency: got %0d expected %0d", lat, e_lat); end
    act_wr_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_directed();
    test_faults();
    test_boundary();
    test_random();
    test_fault_saturation();
    test_reset_mid_copy();
    n_checks++;
    if (oob_wr != 0) begin n_fail++; $display("FAIL out-of-range writes: got %0d expected 0", oob_wr); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
